// File: rtl/enc16to4_req_pkg.sv
// rtl/enc16to4_req_pkg.sv - shared constants, state encoding and index decode for enc16to4_req
package enc16to4_req_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // 4-to-16 decode of an index, used to build the clear mask
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/enc16to4_req_prio_enc16.sv
// rtl/enc16to4_req_prio_enc16.sv - combinational 16-bit highest-set-bit priority encoder
module prio_enc16
  import enc16to4_req_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             nz
);

  // Ascending scan: the last (highest) set bit overwrites lower ones
  always_comb begin
    idx = '0;
    nz  = |vec;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/enc16to4_req.sv
// rtl/enc16to4_req.sv - registered 16-to-4 priority request encoder with valid/ready output
module enc16to4_req
  import enc16to4_req_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] pending,
  output logic             any
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;

  logic [N_REQ-1:0] sel_mask;
  logic [N_REQ-1:0] clr_mask;
  logic [N_REQ-1:0] rem;
  logic [IDX_W-1:0] pend_idx, rem_idx;
  logic             pend_nz, rem_nz;
  logic             accept;

  assign accept   = out_valid_q & out_ready;
  assign sel_mask = onehot(idx_q);
  assign clr_mask = accept ? sel_mask : '0;
  // Remainder uses the registered pending only; same-cycle requests wait a selection
  assign rem      = pending_q & ~sel_mask;

  prio_enc16 u_prio_pend (
    .vec (pending_q),
    .idx (pend_idx),
    .nz  (pend_nz)
  );

  prio_enc16 u_prio_rem (
    .vec (rem),
    .idx (rem_idx),
    .nz  (rem_nz)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    // Set is OR-ed after the clear so a re-raised request survives
    pending_d   = (pending_q & ~clr_mask) | (en ? req : '0);

    unique case (state_q)
      IDLE: begin
        if (pend_nz) begin
          idx_d       = pend_idx;
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          if (rem_nz) begin
            idx_d = rem_idx;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign pending   = pending_q;
  assign any       = |pending_q;

endmodule

// File: tb/tb_enc16to4_req.sv
// tb/tb_enc16to4_req.sv - self-checking bench for enc16to4_req against a behavioural model
module tb_enc16to4_req;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] req;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  idx;
  logic [15:0] pending;
  logic        any;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state
  logic [15:0] m_pend;
  logic        m_valid;
  logic [3:0]  m_idx;

  enc16to4_req dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .idx       (idx),
    .pending   (pending),
    .any       (any)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] highest(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [15:0] nxt;
    logic [15:0] r;
    if (reset) begin
      m_pend = '0; m_valid = 1'b0; m_idx = '0;
    end else begin
      nxt = m_pend;
      if (m_valid && out_ready) nxt[m_idx] = 1'b0;
      if (en) nxt = nxt | req;
      if (!m_valid) begin
        if (m_pend != 0) begin
          m_idx = highest(m_pend); m_valid = 1'b1;
        end
      end else if (out_ready) begin
        r = m_pend;
        r[m_idx] = 1'b0;
        if (r != 0) m_idx = highest(r);
        else        m_valid = 1'b0;
      end
      m_pend = nxt;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pending"}, 32'(pending), 32'(m_pend));
    chk({tag, "_valid"},   32'(out_valid), 32'(m_valid));
    chk({tag, "_any"},     32'(any), 32'(m_pend != 0));
    if (m_valid) begin
      chk({tag, "_idx"}, 32'(idx), 32'(m_idx));
      chk({tag, "_inv"}, 32'(pending[idx]), 32'd1);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; req = 16'hFFFF; out_ready = 1'b0;
    m_pend = '0; m_valid = 1'b0; m_idx = '0;

    // 1. reset
    step("rst1"); step("rst2");
    chk("rst_idx", 32'(idx), 32'd0);
    reset = 1'b0; req = 16'h0000;
    step("idle1"); step("idle2");

    // 2. single request
    req = 16'h0020;
    step("single_cap");
    chk("single_pend", 32'(pending), 32'h0020);
    req = 16'h0000;
    step("single_pres");
    chk("single_idx", 32'(idx), 32'd5);
    step("single_hold");
    out_ready = 1'b1;
    step("single_acc");
    chk("single_done", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // 3. priority and back-to-back
    req = 16'h8101; out_ready = 1'b1;
    step("b2b_cap");
    req = 16'h0000;
    step("b2b_15"); chk("b2b_idx15", 32'(idx), 32'd15);
    step("b2b_8");  chk("b2b_idx8",  32'(idx), 32'd8);
    step("b2b_0");  chk("b2b_idx0",  32'(idx), 32'd0);
    step("b2b_end"); chk("b2b_pend0", 32'(pending), 32'd0);
    out_ready = 1'b0;

    // 4. no preemption
    req = 16'h0008; step("np_cap");
    req = 16'h0000; step("np_pres");
    req = 16'h4000; step("np_hi");
    chk("np_idx3", 32'(idx), 32'd3);
    chk("np_pend", 32'(pending), 32'h4008);
    req = 16'h0000; out_ready = 1'b1;
    step("np_acc"); chk("np_idx14", 32'(idx), 32'd14);
    step("np_end");
    out_ready = 1'b0;

    // 5. set/clear collision
    req = 16'h0004; step("col_cap");
    req = 16'h0000; step("col_pres");
    req = 16'h0004; out_ready = 1'b1;
    step("col_hit"); chk("col_pend", 32'(pending), 32'h0004);
    req = 16'h0000; out_ready = 1'b0;
    step("col_re"); chk("col_idx2", 32'(idx), 32'd2);
    out_ready = 1'b1; step("col_clr");
    out_ready = 1'b0;

    // 6. enable and mid-operation reset
    req = 16'h0002; step("en_cap");
    req = 16'h0000; step("en_pres");
    en = 1'b0; req = 16'h00F0; step("en_off");
    chk("en_pend", 32'(pending), 32'h0002);
    reset = 1'b1; step("mid_rst");
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b0; en = 1'b1; req = 16'h0000;

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      req       = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      reset     = ($urandom_range(0, 59) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
